// File: rtl/spi_slave_cfg.sv
// ----------------------------------------------------------------------------
// spi_slave_cfg
// Configurable SPI slave. nCS, SCK and MOSI are asynchronous to sys_clk. Each
// one passes through a 2-FF synchronizer and a third stage that is used for
// edge detection. The slave has one TX holding buffer in front of the TX shift
// register, and it assembles received words in natural bit order.
//
// Parameters
//   DATA_W    word length in bits (4..32)
//   CPOL      SCK idle level
//   CPHA      0: sample on leading edge, 1: sample on trailing edge
//   MSB_FIRST 1: MSB on the wire first, 0: LSB first
//
// Ports
//   sys_clk   system clock, at least 8x the SCK frequency
//   rst_n     asynchronous active-low reset
//   nCS       chip select, active-low (asynchronous)
//   SCK       SPI clock (asynchronous)
//   MOSI      serial data in (asynchronous)
//   MISO      serial data out (registered)
//   tx_data   next word to transmit
//   tx_load   write strobe for tx_data, accepted only while tx_ready is high
//   tx_ready  TX holding buffer empty
//   rx_data   last complete received word
//   rx_valid  one-cycle pulse when rx_data updates
//   busy      frame in progress (synchronized nCS low)
//   frame_err one-cycle pulse when a frame ends on a partial word
// ----------------------------------------------------------------------------
module spi_slave_cfg #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CPOL      = 0,
    parameter int unsigned CPHA      = 0,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              nCS,
    input  logic              SCK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam bit IDLE_LVL  = (CPOL != 0);
    localparam bit PHASE1    = (CPHA != 0);
    localparam bit MSB_FIRST_B = (MSB_FIRST != 0);

    typedef enum logic {StIdle, StActive} state_t;

    state_t            state;
    logic [2:0]        ncs_sync;
    logic [2:0]        sck_sync;
    logic [2:0]        mosi_sync;
    logic              sck_rise;
    logic              sck_fall;
    logic [DATA_W-1:0] tx_buf;
    logic              tx_full;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [CNT_W-1:0]  bit_cnt;
    logic              word_done;

    logic              lead_edge;
    logic              trail_edge;
    logic              sample_edge;
    logic              shift_edge;
    logic              ncs_fall;
    logic              ncs_high;
    logic              xfer;
    logic [DATA_W-1:0] tx_word;
    logic [DATA_W-1:0] rx_next;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST_B ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST_B ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // Synchronizers. Index 0/1 form the 2-FF synchronizer, index 2 is the
    // history stage for edge detection. The SCK edges are registered once more.
    // That is why the sampled MOSI is taken from index 2: it lines up with the
    // registered edge pulse. The nCS stages reset low. A frame therefore starts
    // only on a real falling edge seen after reset is released.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync  <= 3'b000;
            sck_sync  <= {3{IDLE_LVL}};
            mosi_sync <= 3'b000;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
        end else begin
            ncs_sync  <= {ncs_sync[1:0], nCS};
            sck_sync  <= {sck_sync[1:0], SCK};
            mosi_sync <= {mosi_sync[1:0], MOSI};
            sck_rise  <= sck_sync[1] & ~sck_sync[2];
            sck_fall  <= ~sck_sync[1] & sck_sync[2];
        end
    end

    always_comb begin
        lead_edge   = IDLE_LVL ? sck_fall : sck_rise;
        trail_edge  = IDLE_LVL ? sck_rise : sck_fall;
        sample_edge = PHASE1 ? trail_edge : lead_edge;
        shift_edge  = PHASE1 ? lead_edge : trail_edge;
        ncs_fall    = ncs_sync[2] & ~ncs_sync[1];
        ncs_high    = ncs_sync[1];
        tx_word     = tx_full ? tx_buf : '0;
        rx_next     = MSB_FIRST_B ? {rx_sh[DATA_W-2:0], mosi_sync[2]}
                                  : {mosi_sync[2], rx_sh[DATA_W-1:1]};
        // Buffer -> shift register happens at frame start, and at the first
        // shift edge after a word completes. For CPHA=1 that shift edge is the
        // leading edge of the next word.
        xfer = 1'b0;
        if (state == StIdle) begin
            xfer = ncs_fall;
        end else if (!ncs_high && shift_edge && word_done) begin
            xfer = 1'b1;
        end
    end

    assign tx_ready = ~tx_full;
    assign busy     = (state == StActive);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            MISO      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            tx_buf    <= '0;
            tx_full   <= 1'b0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            // A load that coincides with a transfer is accepted only while the
            // buffer is empty. The transfer then takes zeros and the new word
            // waits for the next transfer.
            if (tx_load && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end else if (xfer) begin
                tx_full <= 1'b0;
            end

            case (state)
                StIdle: begin
                    MISO      <= 1'b0;
                    bit_cnt   <= '0;
                    word_done <= 1'b0;
                    if (ncs_fall) begin
                        state <= StActive;
                        if (!PHASE1) begin
                            MISO  <= first_bit(tx_word);
                            tx_sh <= shift_out(tx_word);
                        end else begin
                            tx_sh <= tx_word;
                        end
                    end
                end
                StActive: begin
                    if (ncs_high) begin
                        state     <= StIdle;
                        MISO      <= 1'b0;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        if (sample_edge) begin
                            rx_sh <= rx_next;
                            if (bit_cnt == LAST_CNT) begin
                                bit_cnt   <= '0;
                                rx_data   <= rx_next;
                                rx_valid  <= 1'b1;
                                word_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (word_done) begin
                                MISO      <= first_bit(tx_word);
                                tx_sh     <= shift_out(tx_word);
                                word_done <= 1'b0;
                            end else begin
                                MISO  <= first_bit(tx_sh);
                                tx_sh <= shift_out(tx_sh);
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_cfg.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_cfg
// Directed bench for spi_slave_cfg. Four instances are driven by a
// time-stepped SPI master:
//   0: mode 0, 8-bit, MSB first
//   1: CPOL=1 CPHA=1, 8-bit
//   2: mode 0, 16-bit
//   3: mode 0, 8-bit, LSB first
// ----------------------------------------------------------------------------
module tb_spi_slave_cfg;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ncs_v;
    logic [3:0]  sck_v;
    logic [3:0]  mosi_v;
    logic [3:0]  load_v;
    logic [15:0] txd;
    wire  [3:0]  miso_v, txr_v, busy_v, rxv_v, ferr_v;
    wire  [7:0]  rxd0, rxd1, rxd3;
    wire  [15:0] rxd2;

    int  checks = 0;
    int  errors = 0;
    int  rxv_cnt  [4];
    int  ferr_cnt [4];
    time rxv_t    [4];
    time samp_t   [4];
    logic [15:0] got;

    always #5 sys_clk = ~sys_clk;

    spi_slave_cfg #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_m0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .nCS(ncs_v[0]), .SCK(sck_v[0]), .MOSI(mosi_v[0]),
        .MISO(miso_v[0]), .tx_data(txd[7:0]), .tx_load(load_v[0]), .tx_ready(txr_v[0]),
        .rx_data(rxd0), .rx_valid(rxv_v[0]), .busy(busy_v[0]), .frame_err(ferr_v[0]));

    spi_slave_cfg #(.DATA_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u_m3 (
        .sys_clk(sys_clk), .rst_n(rst_n), .nCS(ncs_v[1]), .SCK(sck_v[1]), .MOSI(mosi_v[1]),
        .MISO(miso_v[1]), .tx_data(txd[7:0]), .tx_load(load_v[1]), .tx_ready(txr_v[1]),
        .rx_data(rxd1), .rx_valid(rxv_v[1]), .busy(busy_v[1]), .frame_err(ferr_v[1]));

    spi_slave_cfg #(.DATA_W(16), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_w16 (
        .sys_clk(sys_clk), .rst_n(rst_n), .nCS(ncs_v[2]), .SCK(sck_v[2]), .MOSI(mosi_v[2]),
        .MISO(miso_v[2]), .tx_data(txd), .tx_load(load_v[2]), .tx_ready(txr_v[2]),
        .rx_data(rxd2), .rx_valid(rxv_v[2]), .busy(busy_v[2]), .frame_err(ferr_v[2]));

    spi_slave_cfg #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u_lsb (
        .sys_clk(sys_clk), .rst_n(rst_n), .nCS(ncs_v[3]), .SCK(sck_v[3]), .MOSI(mosi_v[3]),
        .MISO(miso_v[3]), .tx_data(txd[7:0]), .tx_load(load_v[3]), .tx_ready(txr_v[3]),
        .rx_data(rxd3), .rx_valid(rxv_v[3]), .busy(busy_v[3]), .frame_err(ferr_v[3]));

    // Pulse counters, sampled away from the active edge
    always @(negedge sys_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rxv_v[k] === 1'b1) begin
                rxv_cnt[k] = rxv_cnt[k] + 1;
                rxv_t[k]   = $time;
            end
            if (ferr_v[k] === 1'b1) ferr_cnt[k] = ferr_cnt[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int k, input logic [15:0] v);
        txd       = v;
        load_v[k] = 1'b1;
        #10;
        load_v[k] = 1'b0;
    endtask

    task automatic frame_begin(input int k);
        ncs_v[k] = 1'b0;
        #100;
    endtask

    task automatic frame_end(input int k);
        ncs_v[k] = 1'b1;
        #100;
    endtask

    // One word (or a partial word) from the master. SCK half period is 60 ns,
    // i.e. 12 sys_clk cycles per SCK period. The MISO bit is captured just
    // before the sampling edge.
    task automatic spi_word(input int k, input bit cpol, input bit cpha, input int nbits,
                            input bit msbf, input logic [15:0] w, output logic [15:0] rd);
        int idx;
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = msbf ? nbits - 1 - i : i;
            if (!cpha) begin
                mosi_v[k] = w[idx];
                #60;
                rd[idx]   = miso_v[k];
                sck_v[k]  = ~cpol;
                samp_t[k] = $time;
                #60;
                sck_v[k]  = cpol;
            end else begin
                sck_v[k]  = ~cpol;
                mosi_v[k] = w[idx];
                #60;
                rd[idx]   = miso_v[k];
                sck_v[k]  = cpol;
                samp_t[k] = $time;
                #60;
            end
        end
        if (!cpha) #60;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rxv_cnt[k] = 0; ferr_cnt[k] = 0; rxv_t[k] = 0; samp_t[k] = 0;
        end
        rst_n  = 1'b0;
        ncs_v  = 4'hF;
        sck_v  = 4'b0010;
        mosi_v = 4'h0;
        load_v = 4'h0;
        txd    = '0;
        #20;
        chk("rst_miso",     32'(miso_v[0]), 32'd0);
        chk("rst_tx_ready", 32'(txr_v), 32'hF);
        chk("rst_busy",     32'(busy_v), 32'd0);
        chk("rst_rx_data",  32'(rxd0), 32'd0);
        chk("rst_rx_valid", 32'(rxv_v), 32'd0);
        chk("rst_frame_err", 32'(ferr_v), 32'd0);
        #20;
        rst_n = 1'b1;
        #40;

        // Mode 0: TX 0xA5, master sends 0x3C
        load(0, 16'h00A5);
        chk("m0_ready_after_load", 32'(txr_v[0]), 32'd0);
        load(0, 16'h00FF);  // buffer full: must be ignored
        frame_begin(0);
        chk("m0_busy", 32'(busy_v[0]), 32'd1);
        chk("m0_ready_after_xfer", 32'(txr_v[0]), 32'd1);
        spi_word(0, 1'b0, 1'b0, 8, 1'b1, 16'h003C, got);
        chk("m0_rx_data", 32'(rxd0), 32'h3C);
        chk("m0_miso_word", 32'(got), 32'hA5);
        chk("m0_rxv_latency", 32'(rxv_t[0] - samp_t[0]), 32'd40);
        frame_end(0);
        chk("m0_idle_busy", 32'(busy_v[0]), 32'd0);
        chk("m0_idle_miso", 32'(miso_v[0]), 32'd0);
        chk("m0_rxv_pulses", 32'(rxv_cnt[0]), 32'd1);
        chk("m0_no_ferr", 32'(ferr_cnt[0]), 32'd0);

        // CPOL=1 CPHA=1, same stimulus
        load(1, 16'h00A5);
        frame_begin(1);
        spi_word(1, 1'b1, 1'b1, 8, 1'b1, 16'h003C, got);
        chk("m3_rx_data", 32'(rxd1), 32'h3C);
        chk("m3_miso_word", 32'(got), 32'hA5);
        chk("m3_rxv_latency", 32'(rxv_t[1] - samp_t[1]), 32'd40);
        frame_end(1);
        chk("m3_rxv_pulses", 32'(rxv_cnt[1]), 32'd1);

        // 16-bit, three words in one frame, only two loaded
        load(2, 16'h1234);
        frame_begin(2);
        load(2, 16'hBEEF);
        chk("w16_ready_full", 32'(txr_v[2]), 32'd0);
        spi_word(2, 1'b0, 1'b0, 16, 1'b1, 16'hCAFE, got);
        chk("w16_rx1", 32'(rxd2), 32'hCAFE);
        chk("w16_tx1", 32'(got), 32'h1234);
        chk("w16_ready_after_w1", 32'(txr_v[2]), 32'd1);
        spi_word(2, 1'b0, 1'b0, 16, 1'b1, 16'h0F0F, got);
        chk("w16_rx2", 32'(rxd2), 32'h0F0F);
        chk("w16_tx2", 32'(got), 32'hBEEF);
        spi_word(2, 1'b0, 1'b0, 16, 1'b1, 16'h5555, got);
        chk("w16_rx3", 32'(rxd2), 32'h5555);
        chk("w16_tx3_zero", 32'(got), 32'h0000);
        frame_end(2);
        chk("w16_rxv_pulses", 32'(rxv_cnt[2]), 32'd3);
        chk("w16_no_ferr", 32'(ferr_cnt[2]), 32'd0);

        // Aborted frame after 5 bits, then a clean 0x81
        frame_begin(0);
        spi_word(0, 1'b0, 1'b0, 5, 1'b1, 16'h0015, got);
        frame_end(0);
        chk("abort_ferr", 32'(ferr_cnt[0]), 32'd1);
        chk("abort_no_rxv", 32'(rxv_cnt[0]), 32'd1);
        chk("abort_rx_kept", 32'(rxd0), 32'h3C);
        frame_begin(0);
        spi_word(0, 1'b0, 1'b0, 8, 1'b1, 16'h0081, got);
        frame_end(0);
        chk("after_abort_rx", 32'(rxd0), 32'h81);
        chk("after_abort_tx_zero", 32'(got), 32'h00);
        chk("after_abort_rxv", 32'(rxv_cnt[0]), 32'd2);
        chk("after_abort_ferr", 32'(ferr_cnt[0]), 32'd1);

        // LSB first
        load(3, 16'h0035);
        frame_begin(3);
        spi_word(3, 1'b0, 1'b0, 8, 1'b0, 16'h0001, got);
        frame_end(3);
        chk("lsb_rx", 32'(rxd3), 32'h01);
        chk("lsb_tx", 32'(got), 32'h35);

        // Reset mid-word
        load(0, 16'h00FF);
        frame_begin(0);
        load(0, 16'h0077);
        spi_word(0, 1'b0, 1'b0, 3, 1'b1, 16'h0000, got);
        chk("pre_rst_miso", 32'(miso_v[0]), 32'd1);
        chk("pre_rst_busy", 32'(busy_v[0]), 32'd1);
        chk("pre_rst_ready", 32'(txr_v[0]), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", 32'(miso_v[0]), 32'd0);
        chk("mid_rst_rx_data", 32'(rxd0), 32'd0);
        chk("mid_rst_rx_valid", 32'(rxv_v[0]), 32'd0);
        chk("mid_rst_ready", 32'(txr_v[0]), 32'd1);
        chk("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        chk("mid_rst_ferr", 32'(ferr_v[0]), 32'd0);
        ncs_v[0] = 1'b1;
        #6;
        #20;
        rst_n = 1'b1;
        #40;
        chk("post_rst_idle", 32'(busy_v[0]), 32'd0);
        load(0, 16'h005A);
        frame_begin(0);
        spi_word(0, 1'b0, 1'b0, 8, 1'b1, 16'h00C3, got);
        frame_end(0);
        chk("post_rst_rx", 32'(rxd0), 32'hC3);
        chk("post_rst_tx", 32'(got), 32'h5A);
        chk("post_rst_rxv", 32'(rxv_cnt[0]), 32'd3);
        chk("post_rst_ferr", 32'(ferr_cnt[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_cfg.md
SPI_SLAVE_CFG -- requirements
Module: spi_slave_cfg

Interface
REQ-001 The block SHALL have one clock, sys_clk; reset rst_n SHALL be asynchronous and active-low.
REQ-002 Parameter DATA_W, default 8, word length in bits (legal range 4..32).
REQ-003 Parameter CPOL, default 0, SCK idle level.
REQ-004 Parameter CPHA, default 0. 0: sample on leading edge; 1: sample on trailing edge.
REQ-005 Parameter MSB_FIRST, default 1. 1: MSB on the wire first; 0: LSB first.
REQ-006 sys_clk  in  1  system clock; the block requires f(sys_clk) >= 8 x f(SCK).
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 nCS  in  1  chip select, active-low, asynchronous to sys_clk.
REQ-009 SCK  in  1  SPI clock, asynchronous.
REQ-010 MOSI  in  1  serial data in, asynchronous.
REQ-011 MISO  out  1  serial data out, registered.
REQ-012 tx_data  in  DATA_W  next word to transmit.
REQ-013 tx_load  in  1  write strobe for tx_data.
REQ-014 tx_ready  out  1  high when the TX holding buffer is empty.
REQ-015 rx_data  out  DATA_W  last complete received word.
REQ-016 rx_valid  out  1  one-cycle pulse when rx_data updates.
REQ-017 busy  out  1  high while synchronized nCS is low.
REQ-018 frame_err  out  1  one-cycle pulse on an aborted partial word.

Function
REQ-019 nCS, SCK and MOSI SHALL each pass through a 2-FF synchronizer; edge detection SHALL use a third register stage.
REQ-020 Leading edge = SCK leaving level CPOL; trailing edge = SCK returning to level CPOL; sample edge = leading if CPHA=0, else trailing; shift edge = the other edge.
REQ-021 Two states: IDLE (synced nCS high) and ACTIVE (synced nCS low); busy SHALL equal (state==ACTIVE).
REQ-022 TX path: one DATA_W holding buffer plus one shift register; tx_load with tx_ready=1 SHALL write the buffer and drop tx_ready next cycle; tx_load with tx_ready=0 SHALL be ignored.
REQ-023 Word transfer (buffer -> shift register, tx_ready -> 1) SHALL occur at IDLE->ACTIVE and, when CPHA=0, at the shift edge following each word-completing sample; when CPHA=1, at the leading edge starting each subsequent word; if the buffer is empty, the shift register SHALL load all zeros.
REQ-024 tx_load in the same cycle as a transfer: the transfer uses the prior buffer contents; the new data enters the buffer and is sent in the next word.
REQ-025 CPHA=0: the first bit SHALL be on MISO within 1 cycle of the transfer at frame start; subsequent bits SHALL update on shift edges. CPHA=1: each bit SHALL update on the leading edge.
REQ-026 Bit order on MISO and MOSI assembly SHALL follow MSB_FIRST; rx_data SHALL always hold the word in natural bit order.
REQ-027 A bit counter 0..DATA_W-1 SHALL advance per sample edge; on the sample at count DATA_W-1 it SHALL wrap to 0, load rx_data and pulse rx_valid for exactly 1 cycle.
REQ-028 rx_valid SHALL rise 3 sys_clk cycles after the first sys_clk edge at which the 2-FF synchronizer captures the completing SCK edge; multi-word frames SHALL be supported without deasserting nCS.
REQ-029 nCS deasserted with counter != 0: frame_err pulses 1 cycle, no rx_valid, partial word discarded, counter cleared; with counter == 0: no error.
REQ-030 In IDLE, MISO SHALL be 0, the counter SHALL be 0 and SCK edges SHALL be ignored; the holding buffer and rx_data SHALL be retained.

Reset
REQ-031 rst_n low SHALL immediately force MISO=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, frame_err=0, counter=0, buffer empty and state IDLE, including mid-word.
REQ-032 After rst_n release, the first frame SHALL start only on a synchronized nCS falling edge.

Verification
REQ-033 Mode 0, DATA_W=8, tx_data=0xA5 loaded, master sends 0x3C -> rx_data=0x3C, one rx_valid pulse, MISO bits 1,0,1,0,0,1,0,1.
REQ-034 CPOL=1, CPHA=1, same stimulus -> identical rx_data, MISO and pulse count.
REQ-035 DATA_W=16, 2-word frame, 0x1234 then 0xBEEF loaded on tx_ready -> two rx_valid pulses, both TX words on MISO, 3rd word zeros if unloaded.
REQ-036 nCS raised after 5 bits -> one frame_err pulse, no rx_valid; next frame of 0x81 received as 0x81.
REQ-037 MSB_FIRST=0, wire bits 1,0,0,0,0,0,0,0 -> rx_data=0x01.
REQ-038 rst_n asserted after bit 3 -> all outputs at REQ-031 values same cycle; a full frame after release is received correctly.
